// File: rtl/muldiv_exec_unit.sv
// Iterative multiply/divide execute unit: radix-2 shift-add multiply and restoring
// shift-subtract divide, 32 iterations plus one sign-fixup cycle, results held in HI/LO.
module muldiv_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_dbz;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_b_mag;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz_out;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [2*WIDTH-1:0] w_prod;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & operand_a[WIDTH-1];
    assign w_b_neg  = w_signed & operand_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~operand_a + WIDTH'(1)) : operand_a;
    assign w_b_mag  = w_b_neg ? (~operand_b + WIDTH'(1)) : operand_b;

    // Multiply: {acc,q} shifts right, adding the multiplier magnitude into acc when q[0] is set.
    assign w_add   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b_mag} : {(WIDTH+1){1'b0}});
    // Divide: remainder in acc, dividend bits shift out of q's MSB while quotient bits shift in.
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b_mag};
    assign w_ge    = ~w_diff[WIDTH];
    assign w_prod  = {r_acc, r_q};

    assign busy        = (r_state == S_CALC) || (r_state == S_FIXUP);
    assign done        = (r_state == S_DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_a_raw   <= '0;
            r_b_mag   <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dbz_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_is_div  <= op[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dbz     <= op[1] && (operand_b == '0);
                        r_a_raw   <= operand_a;
                        r_b_mag   <= w_b_mag;
                        r_acc     <= '0;
                        r_q       <= w_a_mag;
                        r_cnt     <= '0;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (!r_is_div) begin
                            r_acc <= w_add[WIDTH:1];
                            r_q   <= {w_add[0], r_q[WIDTH-1:1]};
                        end else begin
                            r_acc <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], w_ge};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(WIDTH-1)) begin
                            r_state <= S_FIXUP;
                        end
                    end
                end
                S_FIXUP: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (!r_is_div) begin
                            {r_hi, r_lo} <= r_neg_res ? -w_prod : w_prod;
                            r_dbz_out    <= 1'b0;
                        end else if (r_dbz) begin
                            r_lo      <= '1;
                            r_hi      <= r_a_raw;
                            r_dbz_out <= 1'b1;
                        end else begin
                            r_lo      <= r_neg_res ? -r_q : r_q;
                            r_hi      <= r_neg_rem ? -r_acc : r_acc;
                            r_dbz_out <= 1'b0;
                        end
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
